// File: rtl/bcd_digit_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_digit_encoder
//  Purpose  : Sequential binary-to-BCD converter (shift-and-add-3, one input
//             bit per clock). Produces NUM_DIGITS 4-bit BCD digits for the
//             seven_segment display driver. The digit output is registered
//             and changes only when a conversion completes, so a multiplexed
//             display never shows partial results. Values that do not fit in
//             NUM_DIGITS decimal digits saturate to all 9s and raise overflow.
//
//  Ports    : clk      - system clock, rising edge
//             reset    - synchronous reset, active low
//             start    - conversion request, honoured only when idle
//             bin_in   - unsigned binary value, captured with start
//             busy     - conversion in progress
//             done     - one-cycle pulse when digits/overflow update
//             overflow - last result exceeded 10^NUM_DIGITS - 1
//             digits   - BCD result, digit 0 least significant
//
//  Revision : 1.0 - initial release
// ============================================================================

module bcd_digit_encoder #(
    parameter int NUM_DIGITS = 8,
    parameter int BIN_WIDTH  = 27
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [BIN_WIDTH-1:0]       bin_in,
    output logic                       busy,
    output logic                       done,
    output logic                       overflow,
    output logic [NUM_DIGITS-1:0][3:0] digits
);

    localparam int SCR_W = NUM_DIGITS * 4;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t                       state_q,  state_d;
    logic [BIN_WIDTH-1:0]         bin_q,    bin_d;
    logic [SCR_W-1:0]             scr_q,    scr_d;
    logic [CNT_W-1:0]             cnt_q,    cnt_d;
    logic                         sticky_q, sticky_d;
    logic [NUM_DIGITS-1:0][3:0]   digits_q, digits_d;
    logic                         ovf_q,    ovf_d;
    logic                         busy_q,   busy_d;
    logic                         done_q,   done_d;

    // Scratch after the add-3 correction, and the joint left shift of
    // {scratch, binary}. The bit leaving the top of the scratch is the
    // overflow indicator for this step.
    logic [SCR_W-1:0]             scr_adj;
    logic [SCR_W+BIN_WIDTH-1:0]   shift_cat;

    // A digit >= 5 would become >= 10 when doubled; adding 3 first makes the
    // doubling carry correctly into the next decimal digit.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
        assign scr_adj[gi*4 +: 4] = (scr_q[gi*4 +: 4] >= 4'd5)
                                  ? (scr_q[gi*4 +: 4] + 4'd3)
                                  : scr_q[gi*4 +: 4];
    end

    assign shift_cat = {scr_adj, bin_q} << 1;

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        bin_d    = bin_q;
        scr_d    = scr_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        digits_d = digits_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bin_d    = bin_in;
                    scr_d    = '0;
                    sticky_d = 1'b0;
                    cnt_d    = CNT_W'(BIN_WIDTH);
                    state_d  = S_SHIFT;
                end
            end

            S_SHIFT: begin
                {scr_d, bin_d} = shift_cat;
                // Once a bit falls off the top the value can never fit again,
                // so the flag is sticky for the rest of the conversion.
                if (scr_adj[SCR_W-1]) begin
                    sticky_d = 1'b1;
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_FINISH;
                end
            end

            S_FINISH: begin
                if (sticky_q) begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        digits_d[i] = 4'd9;
                    end
                    ovf_d = 1'b1;
                end else begin
                    digits_d = scr_q;
                    ovf_d    = 1'b0;
                end
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered versions of the upcoming state so that no
        // input reaches an output combinationally.
        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_FINISH);
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            bin_q    <= '0;
            scr_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            digits_q <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bin_q    <= bin_d;
            scr_q    <= scr_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            digits_q <= digits_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;
    assign digits   = digits_q;

endmodule

`default_nettype wire

// File: doc/bcd_digit_encoder.md
# bcd_digit_encoder

Sequential binary-to-BCD converter that produces the per-digit 4-bit codes consumed by the `seven_segment` display driver. It accepts an unsigned binary value on a start strobe and converts it with a shift-and-add-3 (double-dabble) engine, one bit per clock. It then presents `NUM_DIGITS` BCD digits on a registered output that stays stable between conversions, so the multiplexed display never shows intermediate values.

## Interface

Parameters:
- `NUM_DIGITS`, 8, number of BCD digits produced. Must match the display's `NUM_SEGMENTS`.
- `BIN_WIDTH`, 27, width of the binary input; must be ≥ 1.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-low reset. Sampled on the rising edge of `clk`; asserted when 0.
- `start`  in  1  conversion request. Sampled only in IDLE.
- `bin_in`  in  BIN_WIDTH  unsigned value; captured on the edge that accepts `start`.
- `busy`  out  1  high while a conversion is in progress.
- `done`  out  1  one-cycle pulse; `digits` and `overflow` are updated on the same edge.
- `overflow`  out  1  last conversion exceeded 10^NUM_DIGITS − 1. Held until the next `done`.
- `digits`  out  [NUM_DIGITS-1:0][3:0]  BCD result. Digit 0 is least significant, and each digit is in 0–9. This port connects directly to the display's `encoded` input.

## Operation

- States are IDLE, SHIFT and FINISH.
- Internal registers:
  - binary shift register, `BIN_WIDTH` bits;
  - BCD scratch, `NUM_DIGITS*4` bits;
  - bit counter, `$clog2(BIN_WIDTH+1)` bits;
  - sticky overflow flag.
- IDLE with `start`=1:
  - latch `bin_in`, clear the scratch and the sticky flag, load counter = `BIN_WIDTH`;
  - go to SHIFT and set `busy`=1.
- IDLE with `start`=0: hold all state.
- SHIFT, each cycle:
  1. In every scratch digit with value ≥ 5, add 3 (4-bit add; the result fits in 4 bits).
  2. Shift {scratch, binary} left by 1. The binary MSB enters scratch bit 0.
  3. If the bit shifted out of the top scratch digit is 1, set the sticky overflow flag.
  4. Decrement the counter. When the counter reaches 1 on this edge, the next state is FINISH.
- FINISH, one cycle:
  - If sticky overflow is set, `digits` ← all 9s (saturated) and `overflow` ← 1.
  - Otherwise `digits` ← scratch and `overflow` ← 0.
  - `done` ← 1, `busy` ← 0, state ← IDLE.
- `start` while `busy`=1 is ignored. The request is not queued.
- `digits` and `overflow` change only on the FINISH edge or on reset. They hold their previous values throughout SHIFT.
- Reset (`reset`=0 on a rising edge) takes priority over every other action, including mid-conversion:
  - state IDLE, counter 0, scratch 0, sticky flag 0;
  - `digits` = all 0, `overflow` = 0, `busy` = 0, `done` = 0.
  - An aborted conversion produces no `done`.

## Timing

- Let E be the edge that accepts `start`.
  - `busy` is 1 after E.
  - The `BIN_WIDTH` shift edges are E+1 … E+BIN_WIDTH.
  - At E+BIN_WIDTH+1, `digits`, `overflow` and `done`=1 become valid, and `busy` returns to 0.
  - Latency from start to done is `BIN_WIDTH`+1 cycles; with defaults this is 28.
- `done` is high for exactly one cycle.
- The FSM is in IDLE during the `done` cycle, so a `start` sampled in that cycle is accepted. Back-to-back throughput is one result every `BIN_WIDTH`+1 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- With defaults, the maximum input is 134,217,727. Inputs from 100,000,000 upward set `overflow`.

## Test plan

- **Basic conversion.** Reset low for 2 cycles, then `bin_in`=12,345,678 with `start` pulsed.
  - `done` arrives exactly 28 cycles later.
  - `digits`[7..0] = 1,2,3,4,5,6,7,8 and `overflow`=0.
  - `busy` is high for 28 cycles.
- **Boundary values.** Run `bin_in`=0, then 99,999,999.
  - First result: all digits 0, `overflow`=0.
  - Second result: all digits 9, `overflow`=0.
- **Overflow.** `bin_in`=100,000,000, then 134,217,727.
  - Both results: all digits 9, `overflow`=1.
  - A following conversion of 42 gives digits 0,…,0,4,2 with `overflow`=0.
- **Back-to-back and ignored start.**
  - Convert 500. Assert `start` with `bin_in`=777 at cycle 10 of that conversion: it is ignored, and the result is 500.
  - Assert `start` with `bin_in`=9 in the `done` cycle: it is accepted, and the next result is 9, 28 cycles later.
  - During each conversion, `digits` holds the prior result on every SHIFT cycle.
- **Reset mid-operation.**
  - Start converting 87,654,321 after a prior result of 55.
  - Drive `reset`=0 for one edge at cycle 15.
  - Next cycle: `digits`=0, `busy`=0, and no `done` occurs.
  - A fresh start with 87,654,321 completes correctly.
- **Randomized check.** 1,000 random `bin_in` values from 0 to 2^27−1, checked against a reference model: decimal digits when the value is ≤ 99,999,999, saturation with `overflow`=1 when it is above.
